// File: rtl/io_output_bank.sv
// Memory-mapped output bank: per-channel static/blink/PWM drive from a prescaled 8-bit phase.
// Reads return one cycle after io_read_en, outputs follow writes by one cycle; no backpressure, every access completes.
module io_output_bank #(
    parameter int          NUM_CHANNELS   = 6,
    parameter int          CHANNEL_WIDTH  = 18,
    parameter logic [31:0] BASE_ADDRESS   = 32'd0,
    parameter logic [23:0] PRESCALE_RESET = 24'd1000
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [31:0]                           io_address,
    input  logic                                  io_write_en,
    input  logic [31:0]                           io_write_data,
    input  logic                                  io_read_en,
    output logic [31:0]                           io_read_data,
    output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_PWM    = 2'd2,
        MODE_RSVD   = 2'd3
    } chan_mode_e;

    typedef struct packed {
        logic [7:0] duty;
        chan_mode_e mode;
    } chan_cfg_t;

    localparam logic [29:0] NUM_WORDS     = 30'(NUM_CHANNELS);
    localparam logic [29:0] PRESCALE_WORD = 30'(2 * NUM_CHANNELS);

    logic [CHANNEL_WIDTH-1:0]              data_q [NUM_CHANNELS];
    chan_cfg_t                             cfg_q  [NUM_CHANNELS];
    logic [23:0]                           prescale_q;
    logic [23:0]                           pcnt_q;
    logic [7:0]                            phase_q;
    logic                                  tick;

    logic [31:0]                           addr_offset;
    logic [29:0]                           word_idx;
    logic                                  addr_aligned;
    logic [NUM_CHANNELS-1:0]               sel_data;
    logic [NUM_CHANNELS-1:0]               sel_mode;
    logic                                  sel_prescale;
    logic [31:0]                           rd_value;
    logic [NUM_CHANNELS-1:0]               chan_on;
    logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] out_next;
    logic                                  unused_wdata;

    // Addresses below the base wrap to huge offsets and therefore decode as unmapped.
    assign addr_offset  = io_address - BASE_ADDRESS;
    assign word_idx     = addr_offset[31:2];
    assign addr_aligned = (addr_offset[1:0] == 2'b00);
    assign sel_prescale = addr_aligned && (word_idx == PRESCALE_WORD);
    assign unused_wdata = ^io_write_data;

    always_comb begin
        sel_data = '0;
        sel_mode = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            sel_data[i] = addr_aligned && (word_idx == 30'(i));
            sel_mode[i] = addr_aligned && (word_idx == NUM_WORDS + 30'(i));
        end
    end

    always_comb begin
        rd_value = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (sel_data[i]) begin
                rd_value = 32'(data_q[i]);
            end
            if (sel_mode[i]) begin
                rd_value = {16'b0, cfg_q[i].duty, 6'b0, cfg_q[i].mode};
            end
        end
        if (sel_prescale) begin
            rd_value = {8'b0, prescale_q};
        end
    end

    assign tick = (pcnt_q == prescale_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale_q <= PRESCALE_RESET;
            pcnt_q     <= '0;
            phase_q    <= '0;
        end else begin
            // A prescale write restarts the period; a tick due on that edge still advances the phase.
            if (io_write_en && sel_prescale) begin
                prescale_q <= io_write_data[23:0];
                pcnt_q     <= '0;
            end else if (tick) begin
                pcnt_q <= '0;
            end else begin
                pcnt_q <= pcnt_q + 24'd1;
            end
            if (tick) begin
                phase_q <= phase_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                data_q[i] <= '0;
                cfg_q[i]  <= '0;
            end
        end else if (io_write_en) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (sel_data[i]) begin
                    data_q[i] <= io_write_data[CHANNEL_WIDTH-1:0];
                end
                if (sel_mode[i]) begin
                    cfg_q[i].duty <= io_write_data[15:8];
                    cfg_q[i].mode <= chan_mode_e'(io_write_data[1:0]);
                end
            end
        end
    end

    always_comb begin
        chan_on  = '0;
        out_next = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            case (cfg_q[i].mode)
                MODE_BLINK: chan_on[i] = !phase_q[7];
                MODE_PWM:   chan_on[i] = (phase_q < cfg_q[i].duty);
                default:    chan_on[i] = 1'b1;
            endcase
            out_next[i*CHANNEL_WIDTH +: CHANNEL_WIDTH] = chan_on[i] ? data_q[i] : '0;
        end
    end

    // Read data uses pre-write register values, so a same-cycle read/write returns the old contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_read_data <= '0;
            out_data     <= '0;
        end else begin
            io_read_data <= io_read_en ? rd_value : 32'h0;
            out_data     <= out_next;
        end
    end

endmodule

// File: doc/io_output_bank.md
IO_OUTPUT_BANK -- requirements
Module: io_output_bank

Interface
REQ-001 Parameter NUM_CHANNELS, default 6: number of output channels; legal range 1..16.
REQ-002 Parameter CHANNEL_WIDTH, default 18: bits per channel; legal range 1..32.
REQ-003 Parameter BASE_ADDRESS, default 0: byte address of channel 0 data register, word aligned.
REQ-004 Parameter PRESCALE_RESET, default 24'd1000: reset value of the prescale register.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-007 io_address  input  32  byte address of the current IO access.
REQ-008 io_write_en  input  1  write strobe, one cycle per write.
REQ-009 io_write_data  input  32  write data.
REQ-010 io_read_en  input  1  read strobe, one cycle per read.
REQ-011 io_read_data  output  32  registered read data; zero when not responding, so it can be ORed with other peripherals.
REQ-012 out_data  output  NUM_CHANNELS*CHANNEL_WIDTH  registered channel outputs; channel i occupies bits [i*CHANNEL_WIDTH +: CHANNEL_WIDTH].

Function
REQ-013 Address map, full 32-bit compare:
- DATA[i] at BASE_ADDRESS+4*i.
- MODE[i] at BASE_ADDRESS+4*(NUM_CHANNELS+i).
- PRESCALE at BASE_ADDRESS+8*NUM_CHANNELS.
- Any other address, including misaligned ones, is unmapped.
REQ-014 Write with io_write_en=1 to DATA[i] loads io_write_data[CHANNEL_WIDTH-1:0].
REQ-015 Write to MODE[i] loads mode=io_write_data[1:0] and duty=io_write_data[15:8].
REQ-016 Write to PRESCALE loads io_write_data[23:0] and clears the prescale counter in the same edge.
REQ-017 Writes to unmapped addresses are ignored with no side effect.
REQ-018 io_read_data updates on the edge after io_read_en=1. It returns the register zero-extended to 32 bits: DATA as {0,data}; MODE as {16'b0,duty,6'b0,mode}; PRESCALE as {8'b0,prescale}.
REQ-019 io_read_data is 0 on any edge where io_read_en=0 or the address is unmapped.
REQ-020 A read and a write to the same register in the same cycle return the pre-write value.
REQ-021 Prescale counter (24 bit) increments every cycle. When it equals PRESCALE it wraps to 0 and asserts an internal one-cycle tick. Tick period is PRESCALE+1 cycles; PRESCALE=0 gives a tick every cycle.
REQ-022 Phase counter (8 bit) increments on each tick and wraps 255->0.
REQ-023 Channel output per mode:
- mode 0 (static): DATA[i].
- mode 1 (blink): DATA[i] when phase[7]=0, else 0.
- mode 2 (PWM): DATA[i] when phase < duty, else 0.
- mode 3: reserved, behaves as mode 0.
REQ-024 PWM boundaries: duty=0 gives a constant 0 output; duty=255 gives output 0 only at phase 255.
REQ-025 out_data is registered from the current DATA, MODE and phase. A write sampled at edge k is visible on out_data after edge k+1.
REQ-026 Only one access per cycle is expected. If io_read_en and io_write_en are both high, both are performed per REQ-020.

Reset
REQ-027 While reset=0, all of the following are 0: DATA[i], MODE[i] (mode and duty), prescale counter, phase, out_data and io_read_data.
REQ-028 While reset=0, PRESCALE=PRESCALE_RESET.
REQ-029 Reset asserted mid-operation clears state asynchronously, without waiting for clk.
REQ-030 Writes and reads presented while reset=0 are discarded.
REQ-031 After reset deasserts, the first tick occurs PRESCALE_RESET+1 cycles later.

Verification
REQ-032 Defaults. Write DATA[0]=32'h3FFFF, then read BASE+0 -> io_read_data=32'h0003FFFF one cycle after the read, and out_data[17:0]=18'h3FFFF after the second edge.
REQ-033 Unmapped access. Write to BASE+8*NUM_CHANNELS+4, then read it -> io_read_data=0 and no register changes. Read with io_read_en=0 -> io_read_data=0.
REQ-034 Blink. Set PRESCALE=0, MODE[1]=1, DATA[1]=5 -> channel 1 shows 5 for 128 cycles, then 0 for 128 cycles, repeating with period 256.
REQ-035 PWM. Set PRESCALE=0, MODE[2]=32'h00004002 (duty 64) -> channel 2 is nonzero for exactly 64 of every 256 cycles. With duty=0, channel 2 stays 0 for 512 cycles.
REQ-036 Same-cycle read/write. Read and write DATA[3] in the same cycle, old=7 and new=9 -> io_read_data=7, and a subsequent read returns 9.
REQ-037 Reset mid-operation. Pulse reset low between clock edges while in PWM mode -> out_data=0 and io_read_data=0 immediately, and PRESCALE reads back PRESCALE_RESET afterwards.
